// File: rtl/fp_mant_div_seq_pkg.sv
// Shared FPU format constants and the sequential-stage state encoding.
// Constants are derived from BUS_WIDTH through constant functions so any stage can size itself.
package fp_mant_div_seq_pkg;

    function automatic int mantissa_size(input int bus_width);
        return (bus_width == 64) ? 52 : 23;
    endfunction

    function automatic int exponent_size(input int bus_width);
        return (bus_width == 64) ? 11 : 8;
    endfunction

    function automatic int bias(input int bus_width);
        return (bus_width == 64) ? 1023 : 127;
    endfunction

    localparam logic [1:0] DIV_ST_IDLE = 2'd0;
    localparam logic [1:0] DIV_ST_DIV  = 2'd1;
    localparam logic [1:0] DIV_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = DIV_ST_IDLE,
        S_DIV  = DIV_ST_DIV,
        S_DONE = DIV_ST_DONE
    } div_state_e;

endpackage

// File: rtl/fp_div_step.sv
// One restoring-division step: compare, conditional subtract, shift.
// Purely combinational; the final step leaves the remainder unshifted.
module fp_div_step #(
    parameter int W = 54
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] div_i,
    input  logic         last_i,
    output logic         bit_o,
    output logic [W-1:0] rem_o
);

    logic [W-1:0] diff;

    assign bit_o = (rem_i >= div_i);
    assign diff  = bit_o ? (rem_i - div_i) : rem_i;
    // diff < div, so its MSB is always clear and the left shift cannot overflow
    assign rem_o = last_i ? diff : (diff << 1);

endmodule

// File: rtl/fp_mant_div_seq.sv
// Radix-2 restoring mantissa divider: ({1,m1} << M) / {1,m2}, one quotient bit per clock.
// Latency M+1 cycles after accept; result held in DONE until consumed, no overlap between ops.
module fp_mant_div_seq
    import fp_mant_div_seq_pkg::*;
#(
    parameter  int BUS_WIDTH     = 64,
    localparam int MANTISSA_SIZE = mantissa_size(BUS_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [MANTISSA_SIZE-1:0] m1,
    input  logic [MANTISSA_SIZE-1:0] m2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*BUS_WIDTH-1:0]   quotient,
    output logic                     sticky
);

    localparam int M     = MANTISSA_SIZE;
    localparam int REM_W = M + 2;
    localparam int CNT_W = $clog2(M + 1);

    div_state_e       state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [M:0]       div_q, div_d;
    logic [M:0]       q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             step_bit;
    logic [REM_W-1:0] step_rem;

    fp_div_step #(.W(REM_W)) u_step (
        .rem_i  (rem_q),
        .div_i  ({1'b0, div_q}),
        .last_i (cnt_q == '0),
        .bit_o  (step_bit),
        .rem_o  (step_rem)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        div_d   = div_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    rem_d   = {2'b01, m1};
                    div_d   = {1'b1, m2};
                    q_d     = '0;
                    cnt_d   = CNT_W'(M);
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                q_d   = {q_q[M-1:0], step_bit};
                rem_d = step_rem;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            div_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode registered state only; the result is exposed just in DONE.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign quotient  = out_valid ? {{(2*BUS_WIDTH-M-1){1'b0}}, q_q} : '0;
    assign sticky    = out_valid & (|rem_q);

endmodule

// File: tb/tb_fp_mant_div_seq.sv
// Self-checking bench for fp_mant_div_seq at BUS_WIDTH 64 and 32.
// Expected results come from a wide-integer division model of ({1,m1}<<M)/{1,m2}.
module tb_fp_mant_div_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic         iv64, ir64, ov64, or64, s64;
    logic [51:0]  a64, b64;
    logic [127:0] q64;

    logic         iv32, ir32, ov32, or32, s32;
    logic [22:0]  a32, b32;
    logic [63:0]  q32;

    int n_chk  = 0;
    int n_pass = 0;

    fp_mant_div_seq #(.BUS_WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64),
        .m1(a64), .m2(b64), .out_valid(ov64), .out_ready(or64),
        .quotient(q64), .sticky(s64)
    );

    fp_mant_div_seq #(.BUS_WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .m1(a32), .m2(b32), .out_valid(ov32), .out_ready(or32),
        .quotient(q32), .sticky(s32)
    );

    function automatic void model(input int m, input logic [63:0] f1, input logic [63:0] f2,
                                  output logic [127:0] q, output logic s);
        logic [127:0] a, b, n;
        a = (128'd1 << m) | {64'd0, f1};
        b = (128'd1 << m) | {64'd0, f2};
        n = a << m;
        q = n / b;
        s = (n % b) != 0;
    endfunction

    task automatic run64(input logic [51:0] f1, input logic [51:0] f2,
                         output logic [127:0] q, output logic s, output int lat);
        @(negedge clk);
        a64 = f1; b64 = f2; iv64 = 1'b1;
        @(posedge clk);
        #1 iv64 = 1'b0;
        lat = 0;
        while (!ov64 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        q = q64; s = s64;
        @(negedge clk); or64 = 1'b1;
        @(posedge clk); #1 or64 = 1'b0;
    endtask

    task automatic start32(input logic [22:0] f1, input logic [22:0] f2, output int lat);
        @(negedge clk);
        a32 = f1; b32 = f2; iv32 = 1'b1;
        @(posedge clk);
        #1 iv32 = 1'b0;
        lat = 0;
        while (!ov32 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        iv64 = 0; or64 = 0; a64 = '0; b64 = '0;
        iv32 = 0; or32 = 0; a32 = '0; b32 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if (ir64 !== 1'b1) $display("FAIL reset_in_ready64 got %b want 1", ir64); else n_pass++;
        n_chk++; if (ov64 !== 1'b0) $display("FAIL reset_out_valid64 got %b want 0", ov64); else n_pass++;
        n_chk++; if (q64 !== '0) $display("FAIL reset_quotient64 got %h want 0", q64); else n_pass++;
        n_chk++; if (s64 !== 1'b0) $display("FAIL reset_sticky64 got %b want 0", s64); else n_pass++;
        n_chk++; if (ir32 !== 1'b1) $display("FAIL reset_in_ready32 got %b want 1", ir32); else n_pass++;
        n_chk++; if (ov32 !== 1'b0) $display("FAIL reset_out_valid32 got %b want 0", ov32); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (ir64 !== 1'b1 || ov64 !== 1'b0)
            $display("FAIL post_reset_idle64 got ready=%b valid=%b want 1/0", ir64, ov64); else n_pass++;
    endtask

    task automatic test_directed;
        logic [51:0]  f1 [4] = '{52'h0, 52'h8000000000000, 52'h0, 52'hFFFFFFFFFFFFF};
        logic [51:0]  f2 [4] = '{52'h0, 52'h0, 52'h8000000000000, 52'h0};
        logic [127:0] eq [4] = '{128'h10000000000000, 128'h18000000000000,
                                 128'h0AAAAAAAAAAAAA, 128'h1FFFFFFFFFFFFF};
        logic         es [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [127:0] q;
        logic         s;
        int           lat;
        for (int i = 0; i < 4; i++) begin
            run64(f1[i], f2[i], q, s, lat);
            n_chk++; if (q !== eq[i]) $display("FAIL directed%0d_quotient got %h want %h", i, q, eq[i]); else n_pass++;
            n_chk++; if (s !== es[i]) $display("FAIL directed%0d_sticky got %b want %b", i, s, es[i]); else n_pass++;
            n_chk++; if (lat != 53) $display("FAIL directed%0d_latency got %0d want 53", i, lat); else n_pass++;
            n_chk++; if (ir64 !== 1'b1) $display("FAIL directed%0d_return_idle got %b want 1", i, ir64); else n_pass++;
        end
    endtask

    task automatic test_random64;
        logic [127:0] q, eq;
        logic         s, es;
        logic [51:0]  f1, f2;
        int           lat;
        for (int i = 0; i < 8; i++) begin
            f1 = {$urandom(), $urandom()} & 52'hFFFFFFFFFFFFF;
            f2 = {$urandom(), $urandom()} & 52'hFFFFFFFFFFFFF;
            model(52, {12'd0, f1}, {12'd0, f2}, eq, es);
            run64(f1, f2, q, s, lat);
            n_chk++; if (q !== eq || s !== es)
                $display("FAIL random64_%0d got q=%h s=%b want q=%h s=%b", i, q, s, eq, es); else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        logic [127:0] eq;
        logic         es;
        int           lat;
        model(23, 64'd0, 64'h400000, eq, es);
        start32(23'h0, 23'h400000, lat);
        n_chk++; if (lat != 24) $display("FAIL bp_latency got %0d want 24", lat); else n_pass++;
        n_chk++; if (q32 !== 64'h555555 || q32 !== eq[63:0])
            $display("FAIL bp_quotient got %h want 555555", q32); else n_pass++;
        n_chk++; if (s32 !== 1'b1) $display("FAIL bp_sticky got %b want 1", s32); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            iv32 = ~iv32;
            a32 = 23'($urandom()); b32 = 23'($urandom());
            @(posedge clk); #1;
            n_chk++; if (ov32 !== 1'b1 || ir32 !== 1'b0)
                $display("FAIL bp_hold%0d_handshake got valid=%b ready=%b want 1/0", i, ov32, ir32); else n_pass++;
            n_chk++; if (q32 !== 64'h555555 || s32 !== 1'b1)
                $display("FAIL bp_hold%0d_result got q=%h s=%b want 555555/1", i, q32, s32); else n_pass++;
        end
        @(negedge clk); iv32 = 1'b0; or32 = 1'b1;
        @(posedge clk); #1 or32 = 1'b0;
        n_chk++; if (ir32 !== 1'b1 || ov32 !== 1'b0)
            $display("FAIL bp_release got ready=%b valid=%b want 1/0", ir32, ov32); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (ir32 !== 1'b1) $display("FAIL bp_no_capture got ready=%b want 1", ir32); else n_pass++;
    endtask

    task automatic test_random32;
        logic [127:0] eq;
        logic         es;
        logic [22:0]  f1, f2;
        int           lat;
        for (int i = 0; i < 4; i++) begin
            f1 = 23'($urandom()); f2 = 23'($urandom());
            model(23, {41'd0, f1}, {41'd0, f2}, eq, es);
            start32(f1, f2, lat);
            n_chk++; if (q32 !== eq[63:0] || s32 !== es || lat != 24)
                $display("FAIL random32_%0d got q=%h s=%b lat=%0d want q=%h s=%b lat=24",
                         i, q32, s32, lat, eq[63:0], es); else n_pass++;
            @(negedge clk); or32 = 1'b1;
            @(posedge clk); #1 or32 = 1'b0;
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] exp_q[$];
        logic         exp_s[$];
        int           acc_cyc[$];
        logic [127:0] eq;
        logic         es;
        int           n_res = 0;
        int           cyc = 0;
        a64 = 52'h123456789ABCD; b64 = 52'hFEDCBA9876543;
        iv64 = 1'b1; or64 = 1'b1;
        while (n_res < 3 && cyc < 400) begin
            @(negedge clk);
            if (ov64) begin
                n_chk++;
                if (exp_q.size() == 0 || q64 !== exp_q[0] || s64 !== exp_s[0])
                    $display("FAIL b2b_result%0d got q=%h s=%b", n_res, q64, s64);
                else n_pass++;
                if (exp_q.size() != 0) begin
                    void'(exp_q.pop_front()); void'(exp_s.pop_front());
                end
                n_res++;
            end
            if (ir64 && acc_cyc.size() < 3) begin
                model(52, {12'd0, a64}, {12'd0, b64}, eq, es);
                exp_q.push_back(eq); exp_s.push_back(es);
                acc_cyc.push_back(cyc);
                @(posedge clk);
                #1;
                a64 = {$urandom(), $urandom()} & 52'hFFFFFFFFFFFFF;
                b64 = {$urandom(), $urandom()} & 52'hFFFFFFFFFFFFF;
                if (acc_cyc.size() == 3) iv64 = 1'b0;
            end
            cyc++;
        end
        iv64 = 1'b0; or64 = 1'b0;
        n_chk++; if (n_res != 3) $display("FAIL b2b_results got %0d want 3", n_res); else n_pass++;
        n_chk++; if (acc_cyc.size() != 3 || acc_cyc[1] - acc_cyc[0] != 55 || acc_cyc[2] - acc_cyc[1] != 55)
            $display("FAIL b2b_throughput got %0d accepts, spacing not 55", acc_cyc.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_div;
        logic [127:0] q;
        logic         s;
        int           lat;
        @(negedge clk);
        a64 = 52'h8000000000000; b64 = 52'h8000000000000; iv64 = 1'b1;
        @(posedge clk);
        #1 iv64 = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if (ir64 !== 1'b1 || ov64 !== 1'b0)
            $display("FAIL midreset_handshake got ready=%b valid=%b want 1/0", ir64, ov64); else n_pass++;
        n_chk++; if (q64 !== '0 || s64 !== 1'b0)
            $display("FAIL midreset_outputs got q=%h s=%b want 0/0", q64, s64); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        n_chk++; if (ov64 !== 1'b0 || ir64 !== 1'b1)
            $display("FAIL midreset_discarded got valid=%b ready=%b want 0/1", ov64, ir64); else n_pass++;
        run64(52'h0, 52'h0, q, s, lat);
        n_chk++; if (q !== 128'h10000000000000 || s !== 1'b0)
            $display("FAIL midreset_next_result got q=%h s=%b want 10000000000000/0", q, s); else n_pass++;
        n_chk++; if (lat != 53) $display("FAIL midreset_next_latency got %0d want 53", lat); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random64();
        test_backpressure();
        test_random32();
        test_back_to_back();
        test_reset_mid_div();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
